seg7_scan_driver: RTL and testbench



---
 rtl/seg7_scan_driver.sv | 138 +++++++++++++
 tb/tb_seg7_scan_driver.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Eight-digit common-anode 7-seg scanner with anti-ghost blanking, BCD decode and whole-display blink.
// Latency: 1 clock from digit/state change to an_n/seg_n/dp_n; free-running, no backpressure.
module seg7_scan_driver #(
  parameter int REFRESH_DIV  = 100_000,
  parameter int BLANK_CYCLES = 1_000,
  parameter int BLINK_DIV    = 25_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] d7,
  input  logic [3:0] d6,
  input  logic [3:0] d5,
  input  logic [3:0] d4,
  input  logic [3:0] d3,
  input  logic [3:0] d2,
  input  logic [3:0] d1,
  input  logic [3:0] d0,
  input  logic [7:0] dp_en,
  input  logic       blink,
  output logic [7:0] an_n,
  output logic [6:0] seg_n,
  output logic       dp_n
);

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [RW-1:0] REF_LAST  = RW'(REFRESH_DIV - 1);
  localparam logic [RW-1:0] BLANK_END = RW'(BLANK_CYCLES);
  localparam logic [BW-1:0] BLK_LAST  = BW'(BLINK_DIV - 1);

  typedef struct packed {
    logic [7:0] an_n;
    logic [6:0] seg_n;
    logic       dp_n;
  } disp_t;

  localparam disp_t DISP_OFF = '{an_n: 8'hFF, seg_n: 7'h7F, dp_n: 1'b1};

  logic [RW-1:0] ref_cnt;
  logic [2:0]    idx;
  logic [BW-1:0] blk_cnt;
  logic          phase;
  logic          ref_wrap;
  logic          blanked;
  logic [3:0]    cur_digit;
  disp_t         disp_d;
  disp_t         disp_q;

  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  assign ref_wrap = (ref_cnt == REF_LAST);

  // Slot timing: idx only moves on the wrap edge, so the new slot always opens blanked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_cnt <= '0;
      idx     <= 3'd0;
    end else if (ref_wrap) begin
      ref_cnt <= '0;
      idx     <= idx + 3'd1;
    end else begin
      ref_cnt <= ref_cnt + 1'b1;
    end
  end

  // Blink phase: held "on" whenever blink is low so re-enabling never starts dark.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_cnt <= '0;
      phase   <= 1'b1;
    end else if (!blink) begin
      blk_cnt <= '0;
      phase   <= 1'b1;
    end else if (blk_cnt == BLK_LAST) begin
      blk_cnt <= '0;
      phase   <= ~phase;
    end else begin
      blk_cnt <= blk_cnt + 1'b1;
    end
  end

  always_comb begin
    cur_digit = 4'hF;
    case (idx)
      3'd0:    cur_digit = d0;
      3'd1:    cur_digit = d1;
      3'd2:    cur_digit = d2;
      3'd3:    cur_digit = d3;
      3'd4:    cur_digit = d4;
      3'd5:    cur_digit = d5;
      3'd6:    cur_digit = d6;
      3'd7:    cur_digit = d7;
      default: cur_digit = 4'hF;
    endcase
  end

  assign blanked = (ref_cnt < BLANK_END) || !phase;

  always_comb begin
    disp_d       = DISP_OFF;
    disp_d.seg_n = decode(cur_digit);
    if (!blanked) begin
      disp_d.an_n = ~(8'h01 << idx);
      disp_d.dp_n = ~dp_en[idx];
    end
  end

  // One register for all three fields keeps anodes and cathodes on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_q <= DISP_OFF;
    end else begin
      disp_q <= disp_d;
    end
  end

  assign an_n  = disp_q.an_n;
  assign seg_n = disp_q.seg_n;
  assign dp_n  = disp_q.dp_n;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: decode table, per-cycle scoreboard against a cycle model, and hand-written corner sequences.
module tb_seg7_scan_driver;

  localparam int REFRESH_DIV  = 4;
  localparam int BLANK_CYCLES = 1;
  localparam int BLINK_DIV    = 16;

  typedef struct {
    logic [3:0] val;
    logic [6:0] seg;
  } dec_vec_t;

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] dig [8];
  logic [7:0] dp_en;
  logic       blink;
  logic [7:0] an_n;
  logic [6:0] seg_n;
  logic       dp_n;

  dec_vec_t vec [16];
  exp_t     sb_q [$];

  int tests = 0;
  int failed = 0;

  int m_ref;
  int m_idx;
  int m_blk;
  bit m_phase;

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .REFRESH_DIV (REFRESH_DIV),
    .BLANK_CYCLES(BLANK_CYCLES),
    .BLINK_DIV   (BLINK_DIV)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .d7   (dig[7]),
    .d6   (dig[6]),
    .d5   (dig[5]),
    .d4   (dig[4]),
    .d3   (dig[3]),
    .d2   (dig[2]),
    .d1   (dig[1]),
    .d0   (dig[0]),
    .dp_en(dp_en),
    .blink(blink),
    .an_n (an_n),
    .seg_n(seg_n),
    .dp_n (dp_n)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ref   = 0;
    m_idx   = 0;
    m_blk   = 0;
    m_phase = 1'b1;
    sb_q.delete();
  endtask

  // Push the output expected after the coming edge, advance the model, then pop and compare.
  task automatic tick();
    exp_t e;
    exp_t got;
    bit   blanked;
    blanked = (m_ref < BLANK_CYCLES) || !m_phase;
    e.an    = blanked ? 8'hFF : ~(8'h01 << m_idx);
    e.seg   = vec[dig[m_idx]].seg;
    e.dp    = blanked ? 1'b1 : ~dp_en[m_idx];
    sb_q.push_back(e);
    if (m_ref == REFRESH_DIV - 1) begin
      m_ref = 0;
      m_idx = (m_idx + 1) % 8;
    end else begin
      m_ref++;
    end
    if (!blink) begin
      m_blk   = 0;
      m_phase = 1'b1;
    end else if (m_blk == BLINK_DIV - 1) begin
      m_blk   = 0;
      m_phase = !m_phase;
    end else begin
      m_blk++;
    end
    @(posedge clk);
    #1;
    got = '{an: an_n, seg: seg_n, dp: dp_n};
    e   = sb_q.pop_front();
    chk("scoreboard", 32'(got), 32'(e));
  endtask

  task automatic wait_an(input logic [7:0] target, input string name);
    bit found;
    found = 1'b0;
    for (int n = 0; n < 64 && !found; n++) begin
      tick();
      if (an_n === target) found = 1'b1;
    end
    chk({name, "_timeout"}, 32'(found), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   cnt;
    int   bad;
    bit   found;
    logic [7:0] lit;

    vec[0]  = '{4'd0,  7'h40};
    vec[1]  = '{4'd1,  7'h79};
    vec[2]  = '{4'd2,  7'h24};
    vec[3]  = '{4'd3,  7'h30};
    vec[4]  = '{4'd4,  7'h19};
    vec[5]  = '{4'd5,  7'h12};
    vec[6]  = '{4'd6,  7'h02};
    vec[7]  = '{4'd7,  7'h78};
    vec[8]  = '{4'd8,  7'h00};
    vec[9]  = '{4'd9,  7'h10};
    vec[10] = '{4'd10, 7'h7F};
    vec[11] = '{4'd11, 7'h7F};
    vec[12] = '{4'd12, 7'h7F};
    vec[13] = '{4'd13, 7'h7F};
    vec[14] = '{4'd14, 7'h7F};
    vec[15] = '{4'd15, 7'h7F};

    rst_n = 1'b0;
    blink = 1'b0;
    dp_en = 8'h00;
    for (int i = 0; i < 8; i++) dig[i] = 4'(i);
    model_reset();

    // Reset held across clock edges.
    repeat (2) @(posedge clk);
    #1;
    chk("reset_an", 32'(an_n), 32'hFF);
    chk("reset_seg", 32'(seg_n), 32'h7F);
    chk("reset_dp", 32'(dp_n), 32'h1);

    // Scan order after release: one blanked edge, then 3 lit + 1 blank per slot.
    rst_n = 1'b1;
    tick();
    chk("first_edge_an", 32'(an_n), 32'hFF);
    for (int s = 0; s < 9; s++) begin
      lit = ~(8'h01 << (s % 8));
      for (int c = 0; c < 3; c++) begin
        tick();
        chk("scan_lit_an", 32'(an_n), 32'(lit));
        if (s == 0) chk("scan_d0_seg", 32'(seg_n), 32'h40);
        if (s == 1) chk("scan_d1_seg", 32'(seg_n), 32'h79);
      end
      tick();
      chk("scan_blank_an", 32'(an_n), 32'hFF);
    end

    // Decode table on digit 0.
    for (int i = 0; i < 16; i++) begin
      dig[0] = vec[i].val;
      wait_an(8'hFE, "decode_wait");
      chk($sformatf("decode_%0d", i), 32'(seg_n), 32'(vec[i].seg));
    end
    dig[0] = 4'd0;

    // Decimal points on digits 4 and 6 only.
    dp_en = 8'h50;
    bad = 0;
    cnt = 0;
    for (int n = 0; n < 64; n++) begin
      tick();
      if (dp_n === 1'b0) cnt++;
      if ((dp_n === 1'b0) != (an_n === 8'hEF || an_n === 8'hBF)) bad++;
    end
    chk("dp_mismatched_cycles", 32'(bad), 32'd0);
    chk("dp_lit_cycles", 32'(cnt), 32'd12);
    dp_en = 8'h00;

    // Blink: 16 on cycles (4 slot blanks), 16 dark, 16 on, then drop blink mid-dark.
    blink = 1'b1;
    cnt = 0;
    for (int n = 0; n < 16; n++) begin tick(); if (an_n === 8'hFF) cnt++; end
    chk("blink_on1_ff", 32'(cnt), 32'd4);
    cnt = 0;
    for (int n = 0; n < 16; n++) begin tick(); if (an_n === 8'hFF) cnt++; end
    chk("blink_off_ff", 32'(cnt), 32'd16);
    cnt = 0;
    for (int n = 0; n < 16; n++) begin tick(); if (an_n === 8'hFF) cnt++; end
    chk("blink_on2_ff", 32'(cnt), 32'd4);
    cnt = 0;
    for (int n = 0; n < 8; n++) begin tick(); if (an_n === 8'hFF) cnt++; end
    chk("blink_off2_ff", 32'(cnt), 32'd8);
    blink = 1'b0;
    tick();
    chk("unblink_edge_an", 32'(an_n), 32'hFF);
    found = 1'b0;
    for (int n = 0; n < 2; n++) begin
      tick();
      if (an_n !== 8'hFF) found = 1'b1;
    end
    chk("unblink_resume", 32'(found), 32'd1);
    repeat (32) tick();

    // Live digit update mid-slot.
    dig[3] = 4'd2;
    wait_an(8'hF7, "live_wait");
    chk("live_before_seg", 32'(seg_n), 32'h24);
    dig[3] = 4'd9;
    tick();
    chk("live_after_seg", 32'(seg_n), 32'h10);
    chk("live_after_an", 32'(an_n), 32'hF7);

    // Asynchronous reset mid-scan, no edge needed.
    wait_an(8'hDF, "async_wait");
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_an", 32'(an_n), 32'hFF);
    chk("async_seg", 32'(seg_n), 32'h7F);
    chk("async_dp", 32'(dp_n), 32'h1);
    model_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    tick();
    chk("restart_first_an", 32'(an_n), 32'hFF);
    tick();
    chk("restart_d0_an", 32'(an_n), 32'hFE);
    chk("restart_d0_seg", 32'(seg_n), 32'h40);
    repeat (40) tick();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
